rsa_modexp_core: RTL and testbench

- Parametrised, handshaked modular-exponentiation engine computing result = base^exp mod modulus.
- Exponent and modulus are runtime inputs, so one instance serves both RSA encrypt (e, n) and decrypt (d, n) paths.
- Operands of any WIDTH are supported.
- Constant-time, bit-serial square-and-multiply with interleaved shift-add modular multiplication. No hardware multiplier.
- Sits between the message/cipher source and the sink, replacing fixed-key, fixed-width exponentiation.

---
 rtl/rsa_modexp_core.sv | 150 +++++++++++++++
 tb/tb_rsa_modexp_core.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/rsa_modexp_core.sv
// Bit-serial square-and-multiply modular exponentiation, result = base^exp mod modulus.
// Constant 2*WIDTH^2+WIDTH+2 cycle latency (1 for modulus<2); result held in DONE until out_ready.
module rsa_modexp_core #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] base,
    input  logic [WIDTH-1:0] exp,
    input  logic [WIDTH-1:0] modulus,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             err,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] LOAD = CW'(WIDTH);

    typedef enum logic [2:0] {IDLE, REDUCE, MUL, SQR, DONE} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    bit_idx;
    logic [WIDTH-1:0] base_r;
    logic [WIDTH-1:0] exp_r;
    logic [WIDTH-1:0] mod_r;
    logic [WIDTH-1:0] r_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH:0]   acc;

    logic             accept;
    logic             mod_bad;
    logic             din;
    logic [WIDTH:0]   mod_x, dbl, red1, sum, red2, step_val;

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE) && !rst;
    assign busy      = (state != IDLE) && !rst;
    assign accept    = in_valid && in_ready;
    assign mod_bad   = modulus < WIDTH'(2);

    // Shared step: REDUCE shifts in a base bit, MUL/SQR double and conditionally add b.
    // acc stays below n, so the WIDTH+1 bit datapath never overflows.
    always_comb begin
        din      = (state == REDUCE) ? base_r[WIDTH-1] : 1'b0;
        mod_x    = {1'b0, mod_r};
        dbl      = (acc << 1) | {{WIDTH{1'b0}}, din};
        red1     = (dbl >= mod_x) ? dbl - mod_x : dbl;
        sum      = red1 + {1'b0, b_r};
        red2     = (sum >= mod_x) ? sum - mod_x : sum;
        step_val = ((state != REDUCE) && mplier[WIDTH-1]) ? red2 : red1;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = mod_bad ? DONE : REDUCE;
            REDUCE:  if (cnt == LOAD) state_nxt = MUL;
            MUL:     if (cnt == LAST) state_nxt = SQR;
            SQR:     if (cnt == LAST) state_nxt = (bit_idx == LAST) ? DONE : MUL;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            base_r  <= '0;
            exp_r   <= '0;
            mod_r   <= '0;
            r_r     <= '0;
            b_r     <= '0;
            mplier  <= '0;
            acc     <= '0;
            result  <= '0;
            err     <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (accept) begin
                        base_r  <= base;
                        exp_r   <= exp;
                        mod_r   <= modulus;
                        cnt     <= '0;
                        bit_idx <= '0;
                        acc     <= '0;
                        if (mod_bad) begin
                            result <= '0;
                            err    <= 1'b1;
                        end
                    end
                end
                REDUCE: begin
                    // Final REDUCE cycle loads b and primes the first MUL with r = 1.
                    if (cnt == LOAD) begin
                        b_r    <= acc[WIDTH-1:0];
                        r_r    <= WIDTH'(1);
                        mplier <= WIDTH'(1);
                        acc    <= '0;
                        cnt    <= '0;
                    end else begin
                        acc    <= step_val;
                        base_r <= base_r << 1;
                        cnt    <= cnt + CW'(1);
                    end
                end
                MUL: begin
                    acc    <= step_val;
                    mplier <= mplier << 1;
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        if (exp_r[0]) r_r <= step_val[WIDTH-1:0];
                        acc    <= '0;
                        cnt    <= '0;
                        mplier <= b_r;
                    end
                end
                SQR: begin
                    acc    <= step_val;
                    mplier <= mplier << 1;
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        b_r     <= step_val[WIDTH-1:0];
                        acc     <= '0;
                        cnt     <= '0;
                        exp_r   <= exp_r >> 1;
                        bit_idx <= bit_idx + CW'(1);
                        mplier  <= r_r;
                        if (bit_idx == LAST) begin
                            result <= r_r;
                            err    <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_modexp_core.sv
// Scoreboard bench for rsa_modexp_core: 8-bit and 16-bit instances, latency, backpressure, abort.
module tb_rsa_modexp_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic iv8, ir8, ov8, or8, er8, bz8;
    logic [7:0] b8, e8, n8, r8;
    logic iv16, ir16, ov16, or16, er16, bz16;
    logic [15:0] b16, e16, n16, r16;

    rsa_modexp_core #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .base(b8), .exp(e8),
        .modulus(n8), .out_valid(ov8), .out_ready(or8), .result(r8), .err(er8), .busy(bz8)
    );

    rsa_modexp_core #(.WIDTH(16)) u16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .base(b16), .exp(e16),
        .modulus(n16), .out_valid(ov16), .out_ready(or16), .result(r16), .err(er16), .busy(bz16)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass = 0;

    task automatic check_eq(input string tag, input longint got, input longint want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, got, want, cyc);
    endtask

    typedef struct {
        longint res;
        bit     er;
        int     lat;
    } exp_t;

    exp_t   q8[$];
    exp_t   q16[$];
    int     acc8[$];
    int     acc16[$];
    bit     seen[2];
    longint held_res[2];
    bit     held_err[2];

    function automatic longint model_pow(input longint b, input longint e, input longint n);
        longint r, x, k;
        r = 1 % n;
        x = b % n;
        k = e;
        while (k > 0) begin
            if (k[0]) r = (r * x) % n;
            x = (x * x) % n;
            k = k >> 1;
        end
        return r;
    endfunction

    task automatic mon(input int id, input bit iv, input bit ir, input bit ov, input bit ordy,
                       input longint res, input bit er);
        exp_t x;
        int   a;
        bit   have;
        if (iv && ir) begin
            if (id == 0) acc8.push_back(cyc + 1);
            else acc16.push_back(cyc + 1);
        end
        if (ov && !seen[id]) begin
            seen[id] = 1'b1;
            have = (id == 0) ? (q8.size() > 0 && acc8.size() > 0) : (q16.size() > 0 && acc16.size() > 0);
            if (!have) begin
                check_eq("spurious_out_valid", ov, 0);
            end else begin
                if (id == 0) begin x = q8.pop_front(); a = acc8.pop_front(); end
                else begin x = q16.pop_front(); a = acc16.pop_front(); end
                held_res[id] = x.res;
                held_err[id] = x.er;
                check_eq(id == 0 ? "result8" : "result16", res, x.res);
                check_eq(id == 0 ? "err8" : "err16", er, x.er);
                check_eq(id == 0 ? "latency8" : "latency16", cyc - a + 1, x.lat);
            end
        end else if (ov) begin
            check_eq("hold_result", res, held_res[id]);
            check_eq("hold_err", er, held_err[id]);
        end
        if (ov && ordy) seen[id] = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mon(0, iv8, ir8, ov8, or8, longint'(r8), er8);
            mon(1, iv16, ir16, ov16, or16, longint'(r16), er16);
        end
    end

    task automatic op(input bit w, input longint b, input longint e, input longint n,
                      input longint want, input int delay);
        exp_t x;
        int   k;
        bit   got;
        x.res = want;
        x.er  = (n < 2);
        x.lat = (n < 2) ? 1 : (w ? 530 : 138);
        if (w) q16.push_back(x); else q8.push_back(x);
        @(posedge clk); #1;
        if (w) begin
            or16 = (delay == 0); iv16 = 1'b1;
            b16 = 16'(b); e16 = 16'(e); n16 = 16'(n);
        end else begin
            or8 = (delay == 0); iv8 = 1'b1;
            b8 = 8'(b); e8 = 8'(e); n8 = 8'(n);
        end
        k = 0; got = 1'b0;
        while (!got && k < 2000) begin
            @(negedge clk); got = w ? ir16 : ir8;
            @(posedge clk); #1; k++;
        end
        check_eq("accept_timeout", got, 1);
        // Scramble operands after capture; the core must ignore them.
        if (w) begin iv16 = 1'b0; b16 = ~b16; e16 = ~e16; n16 = ~n16; end
        else begin iv8 = 1'b0; b8 = ~b8; e8 = ~e8; n8 = ~n8; end
        k = 0; got = 1'b0;
        while (!got && k < 2000) begin
            @(negedge clk); got = w ? ov16 : ov8; k++;
        end
        check_eq("done_timeout", got, 1);
        for (int i = 0; i < delay; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check_eq("valid_held", w ? ov16 : ov8, 1);
        end
        @(posedge clk); #1;
        if (w) or16 = 1'b1; else or8 = 1'b1;
        if (delay > 0) begin @(posedge clk); #1; end
        @(negedge clk);
        check_eq("valid_dropped", w ? ov16 : ov8, 0);
        check_eq("ready_after", w ? ir16 : ir8, 1);
    endtask

    initial begin
        int hi;
        longint c;
        rst = 1'b1;
        iv8 = 1'b0; or8 = 1'b1; b8 = '0; e8 = '0; n8 = '0;
        iv16 = 1'b0; or16 = 1'b1; b16 = '0; e16 = '0; n16 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_in_ready", ir8, 0);
        check_eq("rst_out_valid", ov8, 0);
        check_eq("rst_result", r8, 0);
        check_eq("rst_err", er8, 0);
        check_eq("rst_busy", bz8, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("in_ready_after_rst8", ir8, 1);
        check_eq("in_ready_after_rst16", ir16, 1);

        op(0, 9, 7, 143, 48, 0);
        op(0, 48, 103, 143, 9, 0);
        op(0, 152, 7, 143, 48, 0);
        op(0, 5, 0, 143, 1, 0);
        op(0, 142, 2, 255, 19, 0);
        op(0, 0, 5, 143, 0, 0);
        op(0, 142, 4, 143, 1, 0);
        op(0, 254, 3, 255, 254, 0);
        op(0, 200, 7, 1, 0, 0);
        op(0, 3, 3, 0, 0, 0);
        op(0, 9, 7, 143, 48, 0);
        op(0, 9, 7, 143, 48, 5);

        // Abort mid-operation: no result may ever appear.
        @(posedge clk); #1;
        iv8 = 1'b1; b8 = 8'd9; e8 = 8'd7; n8 = 8'd143;
        @(negedge clk);
        check_eq("abort_accept", ir8, 1);
        @(posedge clk); #1;
        iv8 = 1'b0;
        repeat (49) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check_eq("abort_rst_in_ready", ir8, 0);
        check_eq("abort_rst_busy", bz8, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        acc8.delete();
        @(negedge clk);
        check_eq("abort_in_ready", ir8, 1);
        hi = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ov8) hi++;
        end
        check_eq("abort_no_valid", hi, 0);

        op(1, 2, 10, 1000, 24, 0);
        op(1, 65534, 3, 65535, 65534, 0);
        op(1, 7, 0, 1, 0, 0);

        for (int b = 0; b < 143; b++) begin
            c = model_pow(b, 7, 143);
            op(0, b, 7, 143, c, 0);
            op(0, c, 103, 143, b, 0);
        end

        repeat (5) @(posedge clk);
        check_eq("queue8_drained", q8.size(), 0);
        check_eq("queue16_drained", q16.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
